dm_unit: RTL and testbench
==========================

# dm_unit

Data-memory unit of the M stage. Takes the ALU-computed address and rt store data, performs word/halfword/byte stores with byte-lane enables, and supplies the raw aligned 32-bit word to the load-extension logic (`DE`) downstream. After reset it clears its array with a one-word-per-cycle sweep and holds `busy` so the hazard unit stalls the pipeline. It also emits a registered write-log record consumed by the W-stage trace.

## Interface
- `DEPTH`, 3072: number of 32-bit words.
- `AW`, 12: word-index width, at least clog2(DEPTH).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  M-stage instruction valid (not a bubble).
- `store_type`  in  2  00 none, 01 sw, 10 sh, 11 sb.
- `addr`  in  32  byte address from the ALU.
- `wdata`  in  32  store data (rt value, forwarded).
- `rdata`  out  32  raw word at `addr[AW+1:2]`, fed to `DE.Din`.
- `busy`  out  1  high during reset and during the clear sweep.
- `fault`  out  1  store with misaligned address or word index ≥ DEPTH.
- `log_valid`  out  1  a store was committed on the previous edge.
- `log_addr`  out  32  word-aligned byte address of that store.
- `log_data`  out  32  full merged word after that store.

## Operation
- FSM has two states, CLEAR and READY. Reset forces CLEAR with `ptr` = 0.
- CLEAR: writes 0 to `mem[ptr]` and increments `ptr` each cycle. At `ptr` = DEPTH-1 it goes to READY.
- READY: remains in READY until reset.
- `busy` = reset | (state == CLEAR).
- Word index `widx` = `addr[AW+1:2]`.
- Out of range means `widx` ≥ DEPTH or `addr[31:AW+2]` ≠ 0.
- Misalignment:
  - sw: `addr[1:0]` ≠ 0.
  - sh: `addr[0]` ≠ 0.
  - sb: never misaligned.
- `fault` = en & (store_type ≠ 00) & (misaligned | out of range). It is combinational and forced to 0 while `busy`.
- Byte enables `be[3:0]`:
  - sw: 1111.
  - sh: 1100 if `addr[1]`, else 0011.
  - sb: 0001 shifted left by `addr[1:0]`.
- Lane data:
  - sw: `wdata`.
  - sh: {`wdata[15:0]`, `wdata[15:0]`}.
  - sb: `wdata[7:0]` replicated in all four lanes.
- A store commits on the edge when en & !busy & store_type ≠ 00 & !fault. Only lanes with `be` set are written.
- A faulted store writes nothing. Stores while `busy` are dropped; they are not queued, and the stall upstream guarantees retry.
- `rdata`:
  - Combinational `mem[widx]` when READY and in range.
  - 0 when `busy` or out of range.
  - Load type is ignored; extension belongs to `DE`.
- Log registers are updated each edge:
  - `log_valid` <= the commit condition.
  - When committing: `log_addr` <= {`addr[31:2]`, 2'b00}; `log_data` <= the old word merged with the enabled lanes.

## Timing
- Reset values: state CLEAR, `ptr` 0, `log_valid` 0, `log_addr` 0, `log_data` 0.
- While reset is high: `busy` 1, `rdata` 0, `fault` 0.
- Clear sweep takes exactly DEPTH cycles after reset falls. `busy` falls on the edge that writes `mem[DEPTH-1]`.
- Reset asserted mid-sweep restarts the sweep from `ptr` = 0. Reset while READY re-clears the whole array.
- Store latency is 1 edge. Same-cycle `rdata` at the written address shows the old word; the new word appears after the edge.
- Back-to-back stores to the same word merge correctly: the second store sees the first store's result.
- `log_*` lag the commit by one cycle and stay valid for exactly one cycle per store.

## Structure
- Shared package `mem_pkg` holds:
  - `ST_NONE`/`ST_SW`/`ST_SH`/`ST_SB` encodings.
  - The load-type encodings already used by `DE`: 000 lw, 100 lh, 010 lb.
  - State constants `S_CLEAR`/`S_READY`.
- One sub-module, `be_gen`, is natural: pure combinational `store_type`/`addr[1:0]` → `be`, lane data and misaligned flag. Everything else stays in `dm_unit`.

## Test plan
Bench uses DEPTH=16, AW=4.
- Reset: reset high 3 cycles, then low → `busy` stays 1 exactly 16 cycles, then 0. `rdata` = 0 throughout; all words read 0 afterwards.
- Stores: sw 0x12345678 @0x8, then sb 0xAB @0xB, then sh 0xBEEF @0x8 → `rdata` @0x8 = 0xAB34BEEF. `log_data` sequence 0x12345678, 0xAB345678, 0xAB34BEEF; `log_addr` = 0x8 each time.
- Faults: sw @0x6, sh @0x5, sw @0x40 → `fault` = 1 each cycle, no write, `log_valid` 0.
- Mid-sweep reset: after the clear sweep, sw 0xFFFFFFFF @0x0; pulse reset again and, 5 cycles into the new sweep, pulse reset once more → `busy` lasts 16 cycles after the last reset; @0x0 reads 0.
- Stall: sw with en=1 while `busy` → dropped; after `busy` falls the target reads 0. With en=0 and sw @0x4 → no write, `log_valid` 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the M-stage data memory and the downstream load-extension unit.
package mem_pkg;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SW   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SB   = 2'b11;

    localparam logic [2:0] LD_LW = 3'b000;
    localparam logic [2:0] LD_LH = 3'b100;
    localparam logic [2:0] LD_LB = 3'b010;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    // Number of bytes a load type consumes from the raw word.
    function automatic int unsigned load_bytes(input logic [2:0] ld);
        case (ld)
            LD_LW:   return 4;
            LD_LH:   return 2;
            LD_LB:   return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/be_gen.sv
// Store decode: byte-lane enables, lane-replicated data and alignment check.
module be_gen
    import mem_pkg::*;
(
    input  logic [1:0]  store_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b0000;
        lane_data  = 32'h0;
        misaligned = 1'b0;
        case (store_type)
            ST_SW: begin
                be         = 4'b1111;
                lane_data  = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            ST_SH: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data  = {wdata[15:0], wdata[15:0]};
                misaligned = addr_lo[0];
            end
            ST_SB: begin
                be         = 4'b0001 << addr_lo;
                lane_data  = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_unit.sv
// M-stage data memory: byte-lane stores, raw word reads, post-reset clear sweep and write log.
module dm_unit
    import mem_pkg::*;
#(
    parameter int DEPTH = 3072,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        fault,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data
);

    logic [31:0]   mem [DEPTH];
    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [31:0]   lane_data;
    logic [31:0]   old_word;
    logic [31:0]   merged;
    logic          misaligned;
    logic          oor;
    logic          st_active;
    logic          commit;

    be_gen u_be_gen (
        .store_type (store_type),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (be),
        .lane_data  (lane_data),
        .misaligned (misaligned)
    );

    assign widx      = addr[AW+1:2];
    assign busy      = reset | (state == S_CLEAR);
    assign oor       = (32'(widx) >= 32'(DEPTH)) | (addr[31:AW+2] != '0);
    assign st_active = en & (store_type != ST_NONE);
    assign fault     = ~busy & st_active & (misaligned | oor);
    assign commit    = st_active & ~busy & ~fault;

    // The guard keeps an out-of-range index from ever reaching the array.
    assign old_word = (busy | oor) ? 32'h0 : mem[widx];
    assign rdata    = old_word;

    always_comb begin
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = lane_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CLEAR;
            ptr       <= '0;
            log_valid <= 1'b0;
            log_addr  <= 32'h0;
            log_data  <= 32'h0;
        end else begin
            if (state == S_CLEAR) begin
                ptr <= ptr + AW'(1);
                if (32'(ptr) == 32'(DEPTH - 1)) state <= S_READY;
            end
            log_valid <= commit;
            if (commit) begin
                log_addr <= {addr[31:2], 2'b00};
                log_data <= merged;
            end
        end
    end

    // Array contents are never reset; the sweep clears them one word per cycle.
    always_ff @(posedge clk) begin
        if (!reset && state == S_CLEAR) begin
            mem[ptr] <= 32'h0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dm_unit.sv
// Directed bench for dm_unit with a small 16-word array.
module tb_dm_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  store_type = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        busy;
    logic        fault;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;

    int errors = 0;
    int checks = 0;

    dm_unit #(.DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .store_type (store_type),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .fault      (fault),
        .log_valid  (log_valid),
        .log_addr   (log_addr),
        .log_data   (log_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_fault;
        logic [31:0] exp_rdata;
        logic        exp_lv;
        logic [31:0] exp_laddr;
        logic [31:0] exp_ldata;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until busy drops, giving up after a fixed budget.
    task automatic count_busy(output int n, output logic rdata_nonzero);
        n = 0;
        rdata_nonzero = 1'b0;
        while (busy && n < 64) begin
            if (rdata !== 32'h0) rdata_nonzero = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic read_word(input logic [31:0] a, input logic [31:0] exp, input string name);
        en = 1'b0;
        store_type = 2'b00;
        addr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    initial begin
        int   n;
        logic nz;

        vecs[0]  = '{1'b1, 2'b01, 32'h8,        32'h12345678, 1'b0, 32'h0,        1'b1, 32'h8,  32'h12345678};
        vecs[1]  = '{1'b1, 2'b11, 32'hB,        32'h000000AB, 1'b0, 32'h12345678, 1'b1, 32'h8,  32'hAB345678};
        vecs[2]  = '{1'b1, 2'b10, 32'h8,        32'h0000BEEF, 1'b0, 32'hAB345678, 1'b1, 32'h8,  32'hAB34BEEF};
        vecs[3]  = '{1'b1, 2'b00, 32'h8,        32'hFFFFFFFF, 1'b0, 32'hAB34BEEF, 1'b0, 32'h0,  32'h0};
        vecs[4]  = '{1'b1, 2'b01, 32'h6,        32'hDEADDEAD, 1'b1, 32'h0,        1'b0, 32'h0,  32'h0};
        vecs[5]  = '{1'b1, 2'b10, 32'h5,        32'hDEADDEAD, 1'b1, 32'h0,        1'b0, 32'h0,  32'h0};
        vecs[6]  = '{1'b1, 2'b01, 32'h40,       32'hDEADDEAD, 1'b1, 32'h0,        1'b0, 32'h0,  32'h0};
        vecs[7]  = '{1'b0, 2'b01, 32'h4,        32'h55555555, 1'b0, 32'h0,        1'b0, 32'h0,  32'h0};
        vecs[8]  = '{1'b0, 2'b00, 32'h4,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  32'h0};
        vecs[9]  = '{1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  32'h0};
        vecs[10] = '{1'b1, 2'b11, 32'h1,        32'hFFFFFF7F, 1'b0, 32'h0,        1'b1, 32'h0,  32'h00007F00};
        vecs[11] = '{1'b1, 2'b10, 32'h2,        32'hAAAA1234, 1'b0, 32'h00007F00, 1'b1, 32'h0,  32'h12347F00};
        vecs[12] = '{1'b0, 2'b00, 32'h3,        32'h0,        1'b0, 32'h12347F00, 1'b0, 32'h0,  32'h0};
        vecs[13] = '{1'b1, 2'b11, 32'h3F,       32'h000000C3, 1'b0, 32'h0,        1'b1, 32'h3C, 32'hC3000000};
        vecs[14] = '{1'b0, 2'b00, 32'h3C,       32'h0,        1'b0, 32'hC3000000, 1'b0, 32'h0,  32'h0};
        vecs[15] = '{1'b1, 2'b01, 32'h80000000, 32'h11111111, 1'b1, 32'h0,        1'b0, 32'h0,  32'h0};

        // Reset held three cycles; fault stays low even for a misaligned store.
        en = 1'b1;
        store_type = 2'b01;
        addr = 32'h6;
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_log_valid", 32'(log_valid), 32'd0);
        chk("reset_log_addr", log_addr, 32'h0);
        chk("reset_log_data", log_data, 32'h0);
        en = 1'b0;
        store_type = 2'b00;
        addr = 32'h0;
        reset = 1'b0;
        count_busy(n, nz);
        chk("sweep_cycles", 32'(n), 32'd16);
        chk("sweep_rdata_zero", 32'(nz), 32'd0);
        for (int i = 0; i < 16; i++) read_word(32'(i * 4), 32'h0, "cleared_word");

        for (int i = 0; i < 16; i++) begin
            en = vecs[i].en;
            store_type = vecs[i].st;
            addr = vecs[i].addr;
            wdata = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            tick();
            chk($sformatf("vec%0d_log_valid", i), 32'(log_valid), 32'(vecs[i].exp_lv));
            if (vecs[i].exp_lv) begin
                chk($sformatf("vec%0d_log_addr", i), log_addr, vecs[i].exp_laddr);
                chk($sformatf("vec%0d_log_data", i), log_data, vecs[i].exp_ldata);
            end
        end
        read_word(32'h8, 32'hAB34BEEF, "final_word8");
        read_word(32'h4, 32'h0, "faulted_word1_untouched");

        // Reset pulsed after a full store, then again five cycles into the new sweep.
        en = 1'b1;
        store_type = 2'b01;
        addr = 32'h0;
        wdata = 32'hFFFFFFFF;
        tick();
        read_word(32'h0, 32'hFFFFFFFF, "pre_reset_word0");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("mid_sweep_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n, nz);
        chk("resweep_cycles", 32'(n), 32'd16);
        read_word(32'h0, 32'h0, "resweep_word0");
        read_word(32'h8, 32'h0, "resweep_word8");

        // Stores presented while busy are dropped and never logged.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        en = 1'b1;
        store_type = 2'b01;
        addr = 32'h3C;
        wdata = 32'hCAFEF00D;
        nz = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (fault !== 1'b0) nz = 1'b1;
            tick();
            if (log_valid !== 1'b0) nz = 1'b1;
        end
        chk("stall_dropped", 32'(nz), 32'd0);
        en = 1'b0;
        store_type = 2'b00;
        count_busy(n, nz);
        chk("stall_sweep_cycles", 32'(n), 32'd11);
        read_word(32'h3C, 32'h0, "stall_target_word");
        tick();
        chk("stall_log_valid", 32'(log_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
